// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer read path: scaling-mode encodings,
// scan-out FSM states and the centred-window descriptor.
package fb_pkg;

    localparam int ADDR_W  = 19;
    localparam int PIX_W   = 8;
    localparam int COORD_W = 10;

    localparam logic [1:0] MODE_REP  = 2'b00;
    localparam logic [1:0] MODE_DEC  = 2'b01;
    localparam logic [1:0] MODE_ZOOM = 2'b10;
    localparam logic [1:0] MODE_NONE = 2'b11;

    typedef logic [1:0] fb_state_t;
    localparam fb_state_t ST_WAIT_LOW  = 2'd0;
    localparam fb_state_t ST_WAIT_DONE = 2'd1;
    localparam fb_state_t ST_SHOW      = 2'd2;

    typedef struct packed {
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
        logic [COORD_W-1:0] x_off;
        logic [COORD_W-1:0] y_off;
    } fb_win_t;

    function automatic logic [ADDR_W-1:0] zext_coord(input logic [COORD_W-1:0] c);
        return {{(ADDR_W-COORD_W){1'b0}}, c};
    endfunction

endpackage

// File: rtl/fb_window_calc.sv
// Combinational window geometry: scaling mode in, centred image size and
// top-left offset out. Shared with the ROM-to-RAM copier.
module fb_window_calc
    import fb_pkg::*;
#(
    parameter int IMG_W    = 160,
    parameter int IMG_H    = 120,
    parameter int FATOR    = 2,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic [1:0] mode,
    output fb_win_t    win
);

    localparam logic [COORD_W-1:0] BIG_W   = COORD_W'(IMG_W * FATOR);
    localparam logic [COORD_W-1:0] BIG_H   = COORD_W'(IMG_H * FATOR);
    localparam logic [COORD_W-1:0] SMALL_W = COORD_W'(IMG_W / FATOR);
    localparam logic [COORD_W-1:0] SMALL_H = COORD_W'(IMG_H / FATOR);
    localparam logic [COORD_W-1:0] SCR_W   = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0] SCR_H   = COORD_W'(SCREEN_H);

    logic [COORD_W-1:0] w_sel;
    logic [COORD_W-1:0] h_sel;
    logic [COORD_W-1:0] x_span;
    logic [COORD_W-1:0] y_span;

    always_comb begin
        w_sel = '0;
        h_sel = '0;
        case (mode)
            MODE_REP, MODE_ZOOM: begin
                w_sel = BIG_W;
                h_sel = BIG_H;
            end
            MODE_DEC: begin
                w_sel = SMALL_W;
                h_sel = SMALL_H;
            end
            default: begin
                w_sel = '0;
                h_sel = '0;
            end
        endcase
    end

    assign x_span = SCR_W - w_sel;
    assign y_span = SCR_H - h_sel;

    assign win.w     = w_sel;
    assign win.h     = h_sel;
    assign win.x_off = {1'b0, x_span[COORD_W-1:1]};
    assign win.y_off = {1'b0, y_span[COORD_W-1:1]};

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: maps driver coordinates to RAM read addresses and
// returns pixel colour, background outside the window or while the buffer is
// not ready. Define FB_SCANOUT_INCR_ADDR_EN to use a row-base accumulator
// instead of the y*W multiplier (same cycle-level behaviour for raster scans).
module fb_scanout
    import fb_pkg::*;
#(
    parameter int               IMG_W    = 160,
    parameter int               IMG_H    = 120,
    parameter int               FATOR    = 2,
    parameter int               SCREEN_W = 640,
    parameter int               SCREEN_H = 480,
    parameter int               RAM_LAT  = 1,
    parameter logic [PIX_W-1:0] BG_COLOR = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         seletor,
    input  logic               copy_done,
    input  logic [9:0]         next_x,
    input  logic [9:0]         next_y,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [PIX_W-1:0]   rd_data,
    output logic [PIX_W-1:0]   color_out,
    output logic [1:0]         active_mode,
    output logic               showing,
    output logic               frame_start
);

    fb_win_t     win_sel;
    fb_win_t     win_reg;
    logic [1:0]  active_mode_reg;
    fb_state_t   state_reg;
    fb_state_t   state_next;
    logic        frame_start_reg;
    logic        frame_bound;

    fb_window_calc #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .FATOR    (FATOR),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_window_calc (
        .mode (seletor),
        .win  (win_sel)
    );

    assign frame_bound = (next_x == '0) && (next_y == '0);

    // A stale copy_done must be seen low once before the buffer is trusted.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_WAIT_LOW:  if (!copy_done) state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (frame_bound && copy_done) state_next = ST_SHOW;
            ST_SHOW:      if (frame_bound && (seletor != active_mode_reg)) state_next = ST_WAIT_LOW;
            default:      state_next = ST_WAIT_LOW;
        endcase
        if (active_mode_reg == MODE_NONE) state_next = ST_WAIT_LOW;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_WAIT_LOW;
            active_mode_reg <= MODE_NONE;
            win_reg         <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            frame_start_reg <= frame_bound;
            if (frame_bound) begin
                active_mode_reg <= seletor;
                win_reg         <= win_sel;
            end
        end
    end

    // Stage 1: window hit test and address generation.
    logic [COORD_W:0]   x_end;
    logic [COORD_W:0]   y_end;
    logic               in_win_now;
    logic [COORD_W-1:0] dx;
    logic [ADDR_W-1:0]  addr_calc;

    assign x_end      = {1'b0, win_reg.x_off} + {1'b0, win_reg.w};
    assign y_end      = {1'b0, win_reg.y_off} + {1'b0, win_reg.h};
    assign in_win_now = (next_x >= win_reg.x_off) && ({1'b0, next_x} < x_end) &&
                        (next_y >= win_reg.y_off) && ({1'b0, next_y} < y_end);
    assign dx         = next_x - win_reg.x_off;

`ifdef FB_SCANOUT_INCR_ADDR_EN
    logic [ADDR_W-1:0] row_base_reg;

    // Column 0 is never inside the window, so the row base is ready before use.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_base_reg <= '0;
        end else if (next_x == '0) begin
            if (next_y == win_reg.y_off) begin
                row_base_reg <= '0;
            end else if ((next_y > win_reg.y_off) && ({1'b0, next_y} < y_end)) begin
                row_base_reg <= row_base_reg + zext_coord(win_reg.w);
            end
        end
    end

    assign addr_calc = row_base_reg + zext_coord(dx);
`else
    logic [COORD_W-1:0] dy;

    assign dy        = next_y - win_reg.y_off;
    assign addr_calc = zext_coord(dy) * zext_coord(win_reg.w) + zext_coord(dx);
`endif

    logic [ADDR_W-1:0] rd_addr_reg;
    logic              in_win_reg;
    logic              show_s1_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_reg <= '0;
            in_win_reg  <= 1'b0;
            show_s1_reg <= 1'b0;
        end else begin
            rd_addr_reg <= in_win_now ? addr_calc : '0;
            in_win_reg  <= in_win_now;
            show_s1_reg <= (state_reg == ST_SHOW);
        end
    end

    // Qualifiers travel alongside the RAM read.
    genvar gi;
    generate
        for (gi = 0; gi < RAM_LAT; gi++) begin : g_dly
            logic in_win_dly_reg;
            logic show_dly_reg;
            logic in_win_src;
            logic show_src;

            if (gi == 0) begin : g_src
                assign in_win_src = in_win_reg;
                assign show_src   = show_s1_reg;
            end else begin : g_src
                assign in_win_src = g_dly[gi-1].in_win_dly_reg;
                assign show_src   = g_dly[gi-1].show_dly_reg;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    in_win_dly_reg <= 1'b0;
                    show_dly_reg   <= 1'b0;
                end else begin
                    in_win_dly_reg <= in_win_src;
                    show_dly_reg   <= show_src;
                end
            end
        end
    endgenerate

    logic             pix_ok;
    logic [PIX_W-1:0] color_reg;

    assign pix_ok = g_dly[RAM_LAT-1].in_win_dly_reg && g_dly[RAM_LAT-1].show_dly_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            color_reg <= BG_COLOR;
        end else begin
            color_reg <= pix_ok ? rd_data : BG_COLOR;
        end
    end

    assign rd_addr     = rd_addr_reg;
    assign color_out   = color_reg;
    assign active_mode = active_mode_reg;
    assign showing     = (state_reg == ST_SHOW);
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_fb_scanout.sv
// Randomized raster-scan bench for fb_scanout with a behavioural model of the
// display rules and a per-cycle scoreboard.
module tb_fb_scanout;

    localparam int IMG_W = 160, IMG_H = 120, FATOR = 2;
    localparam int SCREEN_W = 640, SCREEN_H = 480;
    localparam logic [7:0] BG = 8'h00;
    localparam int MAXC = 65536;
    localparam int K_NONE = 0, K_DONE_LO = 1, K_DONE_HI = 2, K_SEL = 3, K_RST = 4;

    logic        clk;
    logic        reset;
    logic [1:0]  seletor;
    logic        copy_done;
    logic [9:0]  next_x;
    logic [9:0]  next_y;
    logic [18:0] rd_addr;
    logic [7:0]  rd_data;
    logic [7:0]  color_out;
    logic [1:0]  active_mode;
    logic        showing;
    logic        frame_start;

    fb_scanout dut (
        .clk         (clk),
        .reset       (reset),
        .seletor     (seletor),
        .copy_done   (copy_done),
        .next_x      (next_x),
        .next_y      (next_y),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .color_out   (color_out),
        .active_mode (active_mode),
        .showing     (showing),
        .frame_start (frame_start)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected results, indexed by the clock edge after which they hold.
    bit e_valid [MAXC];
    bit rst_h   [MAXC];
    bit e_show  [MAXC];
    bit e_fs    [MAXC];
    bit e_src   [MAXC];
    int e_addr  [MAXC];
    int e_mode  [MAXC];
    int e_wm    [MAXC];
    int e_x     [MAXC];
    int e_y     [MAXC];

    int cols [12] = '{1, 159, 160, 279, 280, 319, 320, 359, 360, 479, 480, 639};

    // Stimulus state and model state.
    logic [1:0] sel_v, ev_sel;
    bit   done_v, rst_v, rst_pending;
    int   m_act;
    bit   m_show, m_need_low;
    int   frame_no, shown_px;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pix(input logic [18:0] a);
        logic [18:0] h;
        h = a ^ (a >> 7) ^ (a >> 13);
        return {1'b1, h[6:0]};
    endfunction

    // Framebuffer with one clock of read latency.
    always @(posedge clk) rd_data <= pix(rd_addr);

    function automatic void win_of(input int mode, output int w, output int h,
                                   output int xo, output int yo);
        w  = (mode == 0 || mode == 2) ? IMG_W * FATOR : (mode == 1) ? IMG_W / FATOR : 0;
        h  = (mode == 0 || mode == 2) ? IMG_H * FATOR : (mode == 1) ? IMG_H / FATOR : 0;
        xo = (SCREEN_W - w) / 2;
        yo = (SCREEN_H - h) / 2;
    endfunction

    // Framebuffer address of (x,y) in the given mode, -1 outside the window.
    function automatic int ref_addr(input int mode, input int x, input int y);
        int w, h, xo, yo;
        win_of(mode, w, h, xo, yo);
        if (x >= xo && x < xo + w && y >= yo && y < yo + h) return (y - yo) * w + (x - xo);
        return -1;
    endfunction

    function automatic int next_col(input int x);
        for (int i = 0; i < 12; i++) if (cols[i] > x) return cols[i];
        return 640;
    endfunction

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    task automatic step(input int x, input int y);
        int  k, a;
        bit  bnd;
        @(negedge clk);
        next_x    = 10'(x);
        next_y    = 10'(y);
        reset     = rst_v;
        seletor   = sel_v;
        copy_done = done_v;
        k = cyc + 1;
        if (k >= MAXC) begin
            if (k == MAXC) check("cycle_budget", k, MAXC - 1);
            return;
        end
        rst_h[k] = rst_v;
        e_x[k]   = x;
        e_y[k]   = y;
        e_wm[k]  = m_act;
        if (rst_v) begin
            m_act = 3; m_show = 0; m_need_low = 1;
            e_addr[k] = 0; e_src[k] = 0; e_show[k] = 0; e_mode[k] = 3; e_fs[k] = 0;
        end else begin
            a   = ref_addr(m_act, x, y);
            bnd = (x == 0 && y == 0);
            e_addr[k] = (a < 0) ? 0 : a;
            e_src[k]  = (a >= 0) && m_show;
            if (e_src[k]) shown_px++;
            // Display rules: no image in mode 11; leave on a mode change at a
            // boundary; a buffer must be seen not-done, then done at a boundary.
            if (m_act == 3) begin
                m_show = 0; m_need_low = 1;
            end else if (m_show) begin
                if (bnd && sel_v != 2'(m_act)) begin m_show = 0; m_need_low = 1; end
            end else if (m_need_low) begin
                if (!done_v) m_need_low = 0;
            end else if (bnd && done_v) begin
                m_show = 1;
            end
            if (bnd) m_act = int'(sel_v);
            e_show[k] = m_show; e_mode[k] = m_act; e_fs[k] = bnd;
        end
        e_valid[k] = 1;
    endtask

    task automatic apply(input int kind);
        case (kind)
            K_DONE_LO: done_v = 0;
            K_DONE_HI: done_v = 1;
            K_SEL:     sel_v = ev_sel;
            K_RST:     rst_pending = 1;
            default:   ;
        endcase
    endtask

    task automatic scan_row(input int y);
        int x, n;
        bit special;
        special = (y == 119 || y == 120 || y == 209 || y == 210 || y == 269 ||
                   y == 270 || y == 359 || y == 360);
        step(0, y);
        if (!special && (y < 110 || y > 370)) begin
            step($urandom_range(1, 639), y);
            return;
        end
        x = 0; n = 1;
        forever begin
            if (special || $urandom_range(0, 2) == 0) x = next_col(x);
            else x = x + $urandom_range(60, 220);
            if (x > 639) break;
            if (rst_pending && n == 2) begin
                rst_v = 1; step(x, y); rst_v = 0; rst_pending = 0;
            end else begin
                step(x, y);
            end
            n++;
        end
    endtask

    task automatic frame(input int r1, input int k1, input int r2, input int k2);
        if (bad > 40) return;
        shown_px = 0;
        for (int y = 0; y < SCREEN_H; y++) begin
            if (y == r1) apply(k1);
            if (y == r2) apply(k2);
            scan_row(y);
        end
        frame_no++;
        $display("frame %0d: active_mode=%0d showing=%0b image_pixels=%0d cycle=%0d",
                 frame_no, m_act, m_show, shown_px, cyc);
    endtask

    // Scoreboard: every output, every cycle.
    initial begin : compare
        int m;
        bit rst_win;
        forever begin
            @(posedge clk);
            #2;
            m = cyc;
            if (m >= MAXC || !e_valid[m]) continue;
            check("rd_addr", int'(rd_addr), e_addr[m]);
            check("showing", int'(showing), int'(e_show[m]));
            check("active_mode", int'(active_mode), e_mode[m]);
            check("frame_start", int'(frame_start), int'(e_fs[m]));
            rst_win = rst_h[m] || (m >= 1 && rst_h[m-1]) || (m >= 2 && rst_h[m-2]);
            if (rst_win) check("color_out", int'(color_out), int'(BG));
            else if (m >= 2 && e_valid[m-2])
                check("color_out", int'(color_out),
                      e_src[m-2] ? int'(pix(19'(e_addr[m-2]))) : int'(BG));
            if (!rst_h[m] && e_wm[m] == 0 && e_x[m] == 479 && e_y[m] == 359)
                check("lit_addr_rep_last", int'(rd_addr), 76799);
            if (!rst_h[m] && e_wm[m] == 0 && e_x[m] == 160 && e_y[m] == 120)
                check("lit_addr_rep_first", int'(rd_addr), 0);
            if (!rst_h[m] && e_wm[m] == 1 && e_x[m] == 359 && e_y[m] == 269)
                check("lit_addr_dec_last", int'(rd_addr), 4799);
        end
    end

    initial begin
        // Literal anchors for the reference model.
        check("pin_rep_first", ref_addr(0, 160, 120), 0);
        check("pin_rep_last", ref_addr(0, 479, 359), 76799);
        check("pin_rep_left_out", ref_addr(0, 159, 120), -1);
        check("pin_dec_first", ref_addr(1, 280, 210), 0);
        check("pin_dec_last", ref_addr(1, 359, 269), 4799);
        check("pin_dec_right_out", ref_addr(1, 360, 210), -1);
        check("pin_none", ref_addr(3, 320, 240), -1);
        check("pin_zoom", ref_addr(2, 161, 121), 321);

        reset = 1; seletor = 0; copy_done = 0; next_x = 5; next_y = 5;
        sel_v = 0; done_v = 0; rst_v = 1; rst_pending = 0; ev_sel = 0;
        m_act = 3; m_show = 0; m_need_low = 1; frame_no = 0; shown_px = 0;
        repeat (4) step(5, 5);
        rst_v = 0;

        frame(20, K_DONE_HI, -1, K_NONE);                                // done rises mid-frame
        frame(-1, K_NONE, -1, K_NONE);                                  // mode 00 image
        ev_sel = 2'b01;
        frame($urandom_range(150, 300), K_SEL, -1, K_NONE);             // switch, done stuck high
        frame($urandom_range(40, 150), K_DONE_LO, $urandom_range(250, 400), K_DONE_HI);
        ev_sel = 2'b11;
        frame(-1, K_NONE, $urandom_range(380, 450), K_SEL);             // mode 01 image
        frame(-1, K_NONE, -1, K_NONE);                                  // mode 11, three frames
        frame(-1, K_NONE, -1, K_NONE);
        ev_sel = 2'b10;
        frame(400, K_SEL, -1, K_NONE);
        frame($urandom_range(30, 100), K_DONE_LO, $urandom_range(150, 300), K_DONE_HI);
        frame($urandom_range(150, 250), K_RST, -1, K_NONE);             // zoom image, reset mid-line
        frame($urandom_range(30, 100), K_DONE_LO, $urandom_range(150, 300), K_DONE_HI);
        ev_sel = 2'b00;
        frame(-1, K_NONE, $urandom_range(200, 400), K_SEL);             // zoom image, then switch
        frame(-1, K_NONE, -1, K_NONE);

        repeat (4) step(3, 3);
        @(posedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
